// File: rtl/fetch_if_id_pkg.sv
// Shared widths, defaults and IF/ID update selector for the fetch stage.
package fetch_if_id_pkg;

  localparam int InstBus     = 32;
  localparam int InstAddrBus = 32;

  localparam logic [InstBus-1:0]     INST_NOP_DEF   = 32'h0000_0013;
  localparam logic [InstAddrBus-1:0] RESET_ADDR_DEF = 32'h0000_0000;
  localparam logic [InstAddrBus-1:0] PC_STEP        = 32'd4;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_SKID   = 2'd1,
    IFID_RSP    = 2'd2,
    IFID_BUBBLE = 2'd3
  } ifid_sel_e;

endpackage

// File: rtl/fetch_if_id_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction ROM port and IF/ID outputs.
interface fetch_if_id_if;
  import fetch_if_id_pkg::*;

  logic                   stall_i;
  logic                   jump_en;
  logic [InstAddrBus-1:0] jump_addr;
  logic [InstAddrBus-1:0] inst_addr;
  logic [InstBus-1:0]     inst_rdata;
  logic [InstAddrBus-1:0] IF_pc;
  logic [InstBus-1:0]     IF_inst;
  logic                   IF_valid;

  // master is the fetch stage itself; slave is the core/ROM side
  modport master (
    input  stall_i, jump_en, jump_addr, inst_rdata,
    output inst_addr, IF_pc, IF_inst, IF_valid
  );

  modport slave (
    output stall_i, jump_en, jump_addr, inst_rdata,
    input  inst_addr, IF_pc, IF_inst, IF_valid
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a ROM response that arrived while IF/ID was stalled.
module fetch_skid_buf
  import fetch_if_id_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_drain,
  input  logic                   i_flush,
  input  logic [InstAddrBus-1:0] i_pc,
  input  logic [InstBus-1:0]     i_inst,
  output logic                   o_valid,
  output logic [InstAddrBus-1:0] o_pc,
  output logic [InstBus-1:0]     o_inst
);

  logic                   r_valid;
  logic [InstAddrBus-1:0] r_pc;
  logic [InstBus-1:0]     r_inst;

  // load wins over drain so a drain-and-refill in one cycle keeps the entry full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/fetch_if_id.sv
// PC register, ROM request issue and IF/ID register for the 5-stage core.
// Optional FETCH_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module fetch_if_id
  import fetch_if_id_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_ADDR = RESET_ADDR_DEF,
  parameter logic [InstBus-1:0]     INST_NOP   = INST_NOP_DEF
) (
  input  logic clk,
  input  logic rst,
  fetch_if_id_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [InstAddrBus-1:0] r_pc;
  logic                   r_req_valid;
  logic [InstAddrBus-1:0] r_req_pc;

  logic                   r_if_valid;
  logic [InstAddrBus-1:0] r_if_pc;
  logic [InstBus-1:0]     r_if_inst;

  logic                   w_skid_valid;
  logic [InstAddrBus-1:0] w_skid_pc;
  logic [InstBus-1:0]     w_skid_inst;

  logic      w_stall;
  logic      w_run;
  logic      w_issue;
  logic      w_skid_load;
  logic      w_skid_drain;
  ifid_sel_e w_sel;

  assign w_stall = bus.stall_i && !bus.jump_en;
  assign w_run   = !bus.stall_i && !bus.jump_en;
  // never issue while the skid is full and a response is still in flight
  assign w_issue = w_run && (!w_skid_valid || !r_req_valid);

  assign w_skid_load  = (w_stall && r_req_valid && !w_skid_valid) ||
                        (w_run && w_skid_valid && r_req_valid);
  assign w_skid_drain = w_run && w_skid_valid;

  always_comb begin
    w_sel = IFID_HOLD;
    if (bus.jump_en)       w_sel = IFID_BUBBLE;
    else if (bus.stall_i)  w_sel = IFID_HOLD;
    else if (w_skid_valid) w_sel = IFID_SKID;
    else if (r_req_valid)  w_sel = IFID_RSP;
    else                   w_sel = IFID_BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_ADDR;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else begin
      r_req_valid <= w_issue;
      if (bus.jump_en) begin
        r_pc <= bus.jump_addr;
      end else if (w_issue) begin
        r_pc     <= r_pc + PC_STEP;
        r_req_pc <= r_pc;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_flush (bus.jump_en),
    .i_pc    (r_req_pc),
    .i_inst  (bus.inst_rdata),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_inst  (w_skid_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= INST_NOP;
    end else begin
      case (w_sel)
        IFID_SKID: begin
          r_if_valid <= 1'b1;
          r_if_pc    <= w_skid_pc;
          r_if_inst  <= w_skid_inst;
        end
        IFID_RSP: begin
          r_if_valid <= 1'b1;
          r_if_pc    <= r_req_pc;
          r_if_inst  <= bus.inst_rdata;
        end
        IFID_BUBBLE: begin
          r_if_valid <= 1'b0;
          r_if_inst  <= INST_NOP;
        end
        default: ;
      endcase
    end
  end

  // a response arriving during a stall with the skid already full would be lost
  a_skid_overrun: assert property (@(posedge clk) disable iff (rst)
    !(w_stall && r_req_valid && w_skid_valid));

  assign bus.inst_addr = r_pc;
  assign bus.IF_valid  = r_if_valid;
  assign bus.IF_pc     = r_if_pc;
  assign bus.IF_inst   = r_if_inst;

`ifdef FETCH_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.jump_en && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_if_id.sv
// Self-checking bench for fetch_if_id: directed scenarios then random stall/jump/reset traffic.
// Reference model tracks the delivered PC stream rather than pipeline registers.
module tb_fetch_if_id;
  import fetch_if_id_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_if_id_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  fetch_if_id dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  // synchronous ROM, one-cycle read latency
  always @(posedge clk) bus.inst_rdata <= rom(bus.inst_addr);

  // stream model: next PC to deliver, run-edges since redirect, last delivered
  logic [31:0] m_pc;
  int          m_fill;
  logic        m_valid;
  logic [31:0] m_if_pc;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic j, input logic [31:0] ja);
    rst          = r;
    bus.stall_i  = s;
    bus.jump_en  = j;
    bus.jump_addr = ja;
    @(posedge clk);
    if (r) begin
      m_pc = RESET_ADDR_DEF; m_fill = 0; m_valid = 1'b0; m_if_pc = '0;
      m_stall = '0; m_flush = '0;
    end else if (j) begin
      m_pc = ja; m_fill = 0; m_valid = 1'b0;
      if (m_flush != 32'hFFFF_FFFF) m_flush++;
    end else if (s) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall++;
    end else if (m_fill == 0) begin
      m_fill = 1; m_valid = 1'b0;
    end else begin
      m_valid = 1'b1; m_if_pc = m_pc; m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
    check("if_valid", {31'b0, bus.IF_valid}, {31'b0, m_valid});
    check("if_inst", bus.IF_inst, m_valid ? rom(m_if_pc) : 32'h0000_0013);
    if (m_valid || r) check("if_pc", bus.IF_pc, m_if_pc);
    check("inst_addr", bus.inst_addr, (m_fill != 0) ? m_pc + 32'd4 : m_pc);
`ifdef FETCH_PERF_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    logic        r, s, j;
    logic [31:0] ja;

    // reset, then free-run
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("rst_inst", bus.IF_inst, 32'h0000_0013);
    check("rst_addr", bus.inst_addr, 32'h0);
    run(2);
    check("first_pc", bus.IF_pc, 32'h0);
    check("first_inst", bus.IF_inst, 32'h1000);
    run(2);
    check("pre_stall_pc", bus.IF_pc, 32'h8);
    check("pre_stall_addr", bus.inst_addr, 32'h10);

    // one-cycle stall
    stall(1);
    check("stall1_hold", bus.IF_pc, 32'h8);
    run(1);
    check("stall1_rel0", bus.IF_pc, 32'hC);
    run(2);
    check("stall1_rel2", bus.IF_pc, 32'h14);

    // three-cycle stall
    stall(3);
    check("stall3_hold", bus.IF_pc, 32'h14);
    run(3);
    check("stall3_rel", bus.IF_pc, 32'h20);

    // jump while skid full and stalled
    stall(1);
    cyc(1'b0, 1'b1, 1'b1, 32'h200);
    check("jmp_valid", {31'b0, bus.IF_valid}, 32'h0);
    check("jmp_addr", bus.inst_addr, 32'h200);
    run(2);
    check("jmp_target", bus.IF_pc, 32'h200);
    check("jmp_inst", bus.IF_inst, 32'h1080);

    // reset mid-stall with skid full
    run(2);
    stall(1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("midrst_pc", bus.IF_pc, 32'h0);
    run(2);
    check("midrst_restart", bus.IF_pc, 32'h0);

    // stall right after reset captures nothing
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    stall(2);
    run(3);
    check("post_rst_stall", bus.IF_pc, 32'h4);

    // PC wrap across 32 bits
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    run(5);
    check("wrap_pc", bus.IF_pc, 32'h4);

    // 5 stall cycles, 2 jumps, one overlapping a stall
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    run(2);
    stall(2);
    cyc(1'b0, 1'b1, 1'b1, 32'h40);
    stall(2);
    run(1);
    cyc(1'b0, 1'b0, 1'b1, 32'h80);
    run(1);
`ifdef FETCH_PERF_EN
    check("perf_stall", stall_cnt, 32'd4);
    check("perf_flush", flush_cnt, 32'd2);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 99) < 30);
      j  = ($urandom_range(0, 99) < 6);
      ja = 32'($urandom_range(0, 16383)) << 2;
      cyc(r, s, j, ja);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
